// File: rtl/lsq_mem_scheduler.sv
// Load/store scheduler between the MEM stage and a single-port data memory.
// Latency: load response exactly 1 cycle after acceptance (forwarded or memory path).
// Backpressure: st_ready/ld_ready drop when the store queue is full, during fence drain or reset.
//
// Ports:
//   clk, reset                    - clock; asynchronous active-high reset
//   st_valid/st_ready/st_addr/st_data - store request, posted into an in-order store queue
//   ld_valid/ld_ready/ld_addr     - load request, priority access to the memory port
//   ld_resp_valid/ld_resp_data    - load response, one cycle after acceptance
//   fence_req/fence_done          - level fence request; one-cycle done pulse once the queue is empty
//   mem_write/mem_read/mem_addr/mem_wdata/mem_rdata - single-port memory, registered 1-cycle read
//   sq_count                      - number of occupied store queue entries
// Optional build macro LSQ_STORE_AGE_EN: forces a store pop after the head has
// waited AGE_LIMIT cycles behind loads (the AGE_LIMIT-th cycle is the forced write).
module lsq_mem_scheduler #(
    parameter int SQ_DEPTH  = 4,
    parameter int AGE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [31:0]               st_addr,
    input  logic [31:0]               st_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [31:0]               ld_addr,
    output logic                      ld_resp_valid,
    output logic [31:0]               ld_resp_data,
    input  logic                      fence_req,
    output logic                      fence_done,
    output logic                      mem_write,
    output logic                      mem_read,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic [$clog2(SQ_DEPTH):0] sq_count
);
    localparam int PW = $clog2(SQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     sq_addr_q [SQ_DEPTH];
    logic [31:0]     sq_data_q [SQ_DEPTH];
    logic            resp_vld_q, resp_src_q;
    logic [31:0]     fwd_data_q;

    logic            not_full, run_open, age_force;
    logic            push, pop, ld_acc, ld_mem;
    logic            fwd_hit;
    logic [31:0]     fwd_data;
    logic [PW-1:0]   scan_idx;

    // Acceptance is closed while reset is held and from the very cycle a fence is raised.
    assign not_full = count_q < CW'(SQ_DEPTH);
    assign run_open = !reset && (state_q == RUN) && !fence_req;
    assign st_ready = run_open && not_full;
    assign ld_ready = run_open && not_full && !age_force;

    assign push   = st_valid && st_ready;
    assign ld_acc = ld_valid && ld_ready;
    assign ld_mem = ld_acc && !fwd_hit;
    // The port goes to a memory-path load first; otherwise the head store drains.
    assign pop    = (count_q != '0) && !ld_mem;

`ifdef LSQ_STORE_AGE_EN
    localparam int AW = $clog2(AGE_LIMIT) + 1;
    logic [AW-1:0] age_q;

    // age_q counts cycles the head already lost the port; the next blocked cycle would
    // be the AGE_LIMIT-th, so that one is taken by the store instead.
    assign age_force = (count_q != '0) && (age_q == AW'(AGE_LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_q <= '0;
        end else if ((count_q == '0) || pop) begin
            age_q <= '0;
        end else begin
            age_q <= age_q + AW'(1);
        end
    end
`else
    assign age_force = 1'b0;
`endif

    // Scan queued entries oldest to youngest so the youngest match wins.
    // The store being enqueued this cycle is not yet in the array, so it stays invisible.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = head_q;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (sq_addr_q[scan_idx][9:2] == ld_addr[9:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = sq_data_q[scan_idx];
            end
        end
    end

    always_comb begin
        mem_read  = ld_mem;
        mem_write = pop;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_mem) begin
            mem_addr = ld_addr;
        end else if (pop) begin
            mem_addr  = sq_addr_q[head_q];
            mem_wdata = sq_data_q[head_q];
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Fence FSM: the RUN cycle that sees fence_req already behaves as drain,
    // so an empty queue completes the fence in that same cycle.
    always_comb begin
        state_d    = state_q;
        fence_done = 1'b0;
        case (state_q)
            RUN: begin
                if (fence_req && !reset) begin
                    if (count_q == '0) begin
                        fence_done = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    fence_done = !reset;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            resp_vld_q <= 1'b0;
            resp_src_q <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            resp_vld_q <= ld_acc;
            resp_src_q <= ld_mem;
            if (ld_acc && fwd_hit) begin
                fwd_data_q <= fwd_data;
            end
        end
    end

    // Queue payload needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            sq_addr_q[tail_q] <= st_addr;
            sq_data_q[tail_q] <= st_data;
        end
    end

    assign ld_resp_valid = resp_vld_q;
    assign ld_resp_data  = !resp_vld_q ? 32'h0 : (resp_src_q ? mem_rdata : fwd_data_q);
    assign sq_count      = count_q;

endmodule

// File: tb/tb_lsq_mem_scheduler.sv
// Bench for lsq_mem_scheduler: table-driven per-cycle vectors plus hand sequences.
// Load data is checked by a scoreboard fed from an architectural (program-order) memory model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_lsq_mem_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid, st_ready, ld_valid, ld_ready, ld_resp_valid;
    logic [31:0] st_addr, st_data, ld_addr, ld_resp_data;
    logic        fence_req, fence_done, mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  sq_count;

    always #5 clk = ~clk;

    lsq_mem_scheduler #(.SQ_DEPTH(4), .AGE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .fence_req(fence_req), .fence_done(fence_done),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .sq_count(sq_count)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 17) ? 32'h0000_1234 : (32'hD000_0000 | 32'(i));
    endfunction

    // Physical memory: write at the edge, registered 1-cycle read.
    logic [31:0] pmem [256];
    logic        pm_init = 1'b0;
    always @(posedge clk) begin
        if (!pm_init) begin
            for (int i = 0; i < 256; i++) pmem[i] <= init_word(i);
            pm_init <= 1'b1;
        end else begin
            if (mem_write) pmem[mem_addr[9:2]] <= mem_wdata;
            if (mem_read)  mem_rdata <= pmem[mem_addr[9:2]];
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] arch_mem [256];
    logic [31:0] exp_q [$];
    logic        resp_pending = 1'b0;

    logic        s_st_rdy, s_ld_rdy, s_mw, s_mr, s_fd, s_rvld;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  s_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        s_st_rdy = st_ready;  s_ld_rdy = ld_ready;  s_mw = mem_write;  s_mr = mem_read;
        s_addr = mem_addr;    s_wdata = mem_wdata;  s_fd = fence_done; s_cnt = sq_count;
        s_rvld = ld_resp_valid; s_rdata = ld_resp_data;
        if (reset) begin
            exp_q.delete();
            resp_pending = 1'b0;
            return;
        end
        if (resp_pending) begin
            chk("ld_resp_valid", ld_resp_valid, 1);
            if (exp_q.size() > 0) chk("ld_resp_data", ld_resp_data, exp_q.pop_front());
        end else if (ld_resp_valid) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ld_resp actual=1 required=0");
        end
        resp_pending = ld_valid && ld_ready;
        // Program order: an accepted load sees stores accepted before it, not the same-cycle one.
        if (resp_pending) exp_q.push_back(arch_mem[ld_addr[9:2]]);
        if (st_valid && st_ready) arch_mem[st_addr[9:2]] = st_data;
    endtask

    task automatic tick();
        #1;
        sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic st_v; logic [31:0] st_a; logic [31:0] st_d;
        logic ld_v; logic [31:0] ld_a; logic fence;
        logic e_st; logic e_ld; logic e_mw; logic e_mr;
        logic [31:0] e_addr; logic [31:0] e_wd; logic [2:0] e_cnt; logic e_fd;
    } vec_t;

    function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                input logic lv, input logic [31:0] la, input logic fe,
                                input logic est, input logic eld, input logic emw, input logic emr,
                                input logic [31:0] ea, input logic [31:0] ewd,
                                input logic [2:0] ec, input logic efd);
        vec_t v;
        v.st_v = sv; v.st_a = sa; v.st_d = sd; v.ld_v = lv; v.ld_a = la; v.fence = fe;
        v.e_st = est; v.e_ld = eld; v.e_mw = emw; v.e_mr = emr;
        v.e_addr = ea; v.e_wd = ewd; v.e_cnt = ec; v.e_fd = efd;
        return v;
    endfunction

    task automatic idle_inputs();
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; fence_req = 1'b0;
    endtask

    vec_t vecs [$];
    int   first_w, lr_at, mr_at, nw, nlr;
    int   words [9] = '{4, 8, 12, 17, 64, 65, 66, 67, 80};

    initial begin
        for (int i = 0; i < 256; i++) arch_mem[i] = init_word(i);

        //                 st_v st_a      st_d          ld_v ld_a      fen  st ld mw mr addr      wdata         cnt fd
        vecs.push_back(mk(1, 32'h10,  32'hA5A5A5A5, 0, 32'h0,   0,  1, 1, 0, 0, 32'h0,   32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,   0,  1, 1, 1, 0, 32'h10,  32'hA5A5A5A5, 1, 0));
        vecs.push_back(mk(1, 32'h20,  32'h1,        1, 32'h44,  0,  1, 1, 0, 1, 32'h44,  32'h0,        0, 0));
        vecs.push_back(mk(1, 32'h20,  32'h2,        1, 32'h48,  0,  1, 1, 0, 1, 32'h48,  32'h0,        1, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h20,  0,  1, 1, 1, 0, 32'h20,  32'h1,        2, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,   0,  1, 1, 1, 0, 32'h20,  32'h2,        1, 0));
        vecs.push_back(mk(1, 32'h30,  32'h7,        1, 32'h30,  0,  1, 1, 0, 1, 32'h30,  32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h32,  0,  1, 1, 1, 0, 32'h30,  32'h7,        1, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,   0,  1, 1, 0, 0, 32'h0,   32'h0,        0, 0));
        // Fill the queue behind loads, then stall on full, then fence with three queued.
        vecs.push_back(mk(1, 32'h100, 32'h11,       1, 32'h200, 0,  1, 1, 0, 1, 32'h200, 32'h0,        0, 0));
        vecs.push_back(mk(1, 32'h104, 32'h22,       1, 32'h200, 0,  1, 1, 0, 1, 32'h200, 32'h0,        1, 0));
        vecs.push_back(mk(1, 32'h108, 32'h33,       1, 32'h200, 0,  1, 1, 0, 1, 32'h200, 32'h0,        2, 0));
        vecs.push_back(mk(1, 32'h10C, 32'h44,       1, 32'h200, 0,  1, 1, 0, 1, 32'h200, 32'h0,        3, 0));
        vecs.push_back(mk(1, 32'h110, 32'h55,       1, 32'h200, 0,  0, 0, 1, 0, 32'h100, 32'h11,       4, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h200, 0,  1, 1, 0, 1, 32'h200, 32'h0,        3, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h200, 1,  0, 0, 1, 0, 32'h104, 32'h22,       3, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h200, 1,  0, 0, 1, 0, 32'h108, 32'h33,       2, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h200, 1,  0, 0, 1, 0, 32'h10C, 32'h44,       1, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        1, 32'h200, 1,  0, 0, 0, 0, 32'h0,   32'h0,        0, 1));
        vecs.push_back(mk(0, 32'h0,   32'h0,        0, 32'h0,   0,  1, 1, 0, 0, 32'h0,   32'h0,        0, 0));

        // Reset with requests and fence asserted: nothing may be accepted or driven.
        idle_inputs();
        st_valid = 1'b1; ld_valid = 1'b1; ld_addr = 32'h44; st_addr = 32'h10; fence_req = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        chk("rst st_ready", s_st_rdy, 0);
        chk("rst ld_ready", s_ld_rdy, 0);
        chk("rst mem_write", s_mw, 0);
        chk("rst mem_read", s_mr, 0);
        chk("rst mem_addr", s_addr, 0);
        chk("rst mem_wdata", s_wdata, 0);
        chk("rst sq_count", s_cnt, 0);
        chk("rst ld_resp_valid", s_rvld, 0);
        chk("rst ld_resp_data", s_rdata, 0);
        chk("rst fence_done", s_fd, 0);
        idle_inputs();
        reset = 1'b0;

        foreach (vecs[i]) begin
            st_valid = vecs[i].st_v; st_addr = vecs[i].st_a; st_data = vecs[i].st_d;
            ld_valid = vecs[i].ld_v; ld_addr = vecs[i].ld_a; fence_req = vecs[i].fence;
            tick();
            chk($sformatf("row%0d st_ready", i), s_st_rdy, vecs[i].e_st);
            chk($sformatf("row%0d ld_ready", i), s_ld_rdy, vecs[i].e_ld);
            chk($sformatf("row%0d mem_write", i), s_mw, vecs[i].e_mw);
            chk($sformatf("row%0d mem_read", i), s_mr, vecs[i].e_mr);
            chk($sformatf("row%0d mem_addr", i), s_addr, vecs[i].e_addr);
            chk($sformatf("row%0d mem_wdata", i), s_wdata, vecs[i].e_wd);
            chk($sformatf("row%0d sq_count", i), s_cnt, vecs[i].e_cnt);
            chk($sformatf("row%0d fence_done", i), s_fd, vecs[i].e_fd);
        end
        idle_inputs();

        // Fence on an empty queue completes in its first cycle.
        fence_req = 1'b1;
        tick();
        chk("empty fence_done", s_fd, 1);
        chk("empty fence st_ready", s_st_rdy, 0);
        fence_req = 1'b0;
        tick();
        chk("after fence fence_done", s_fd, 0);
        chk("after fence st_ready", s_st_rdy, 1);

        // One store behind a continuous stream of memory-path loads.
        st_valid = 1'b1; st_addr = 32'h140; st_data = 32'h99;
        ld_valid = 1'b1; ld_addr = 32'h200;
        tick();
        st_valid = 1'b0;
        first_w = 0; lr_at = -1; mr_at = -1; nw = 0; nlr = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (s_mw) nw++;
            if (s_ld_rdy) nlr++;
            if (s_mw && first_w == 0) begin
                first_w = c; lr_at = int'(s_ld_rdy); mr_at = int'(s_mr);
            end
        end
`ifdef LSQ_STORE_AGE_EN
        chk("age forced write cycle", first_w, 8);
        chk("age ld_ready at force", lr_at, 0);
        chk("age mem_read at force", mr_at, 0);
`else
        chk("no age write count", nw, 0);
        chk("loads never stalled", nlr, 10);
        chk("store still queued", s_cnt, 1);
`endif
        ld_valid = 1'b0;
        tick();
`ifndef LSQ_STORE_AGE_EN
        chk("idle drain mem_write", s_mw, 1);
        chk("idle drain mem_addr", s_addr, 32'h140);
`endif
        tick();
        chk("age section sq_count", s_cnt, 0);

        // Reset mid-operation discards queued stores and the pending load response.
        st_valid = 1'b1; st_addr = 32'h300; st_data = 32'hDEAD;
        ld_valid = 1'b1; ld_addr = 32'h200;
        tick();
        st_addr = 32'h304; st_data = 32'hBEEF;
        tick();
        chk("pre-reset sq_count", s_cnt, 1);
        idle_inputs();
        reset = 1'b1;
        tick();
        chk("mid reset sq_count", s_cnt, 0);
        chk("mid reset ld_resp_valid", s_rvld, 0);
        reset = 1'b0;
        nw = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (s_mw) nw++;
        end
        chk("post reset writes", nw, 0);
        chk("discarded store 0x300", pmem[192], init_word(192));
        chk("discarded store 0x304", pmem[193], init_word(193));

        foreach (words[i]) chk($sformatf("final mem word%0d", words[i]), pmem[words[i]], arch_mem[words[i]]);
        chk("scoreboard empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
